// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared state type, pattern width and geometry helpers for sprite_blitter
// Optional feature macro: CHIP8_SPRITE16_EN (16x16 sprites when n = 0, 24-bit pattern).
// Contents: state_t (FSM states), PAT_W/PAT_BYTES/SPR_W (datapath widths),
//           fb_row_bytes()/fb_bytes() (framebuffer geometry from the display parameters).
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SPR_RD,
    SPR_LATCH,
    FB_RD,
    FB_WAIT,
    FB_WR,
    DONE
  } state_t;

`ifdef CHIP8_SPRITE16_EN
  localparam int PAT_W = 24;
`else
  localparam int PAT_W = 16;
`endif
  localparam int PAT_BYTES = PAT_W / 8;
  // Sprite row width feeding the shifter: 8 bits, or 16 with wide sprites.
  localparam int SPR_W = PAT_W - 8;

  function automatic int fb_row_bytes(input int screen_w);
    return screen_w / 8;
  endfunction

  function automatic int fb_bytes(input int screen_w, input int screen_h);
    return (screen_w * screen_h) / 8;
  endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// rtl/sprite_row_shifter.sv - aligns one sprite row to the framebuffer byte grid
// Optional feature macro: CHIP8_SPRITE16_EN (via ppu_pkg widths).
// Ports: sprite  in  SPR_W      sprite row, leftmost pixel in the MSB
//        shift   in  3          x0 % 8
//        pattern out PAT_W      row shifted right by x0 % 8; byte k = pattern[PAT_W-1-8k -: 8]
//        nonzero out PAT_BYTES  bit k set when pattern byte k has any pixel set
module sprite_row_shifter
  import ppu_pkg::*;
(
  input  logic [SPR_W-1:0]     sprite,
  input  logic [2:0]           shift,
  output logic [PAT_W-1:0]     pattern,
  output logic [PAT_BYTES-1:0] nonzero
);

  always_comb begin
    pattern = {sprite, 8'h00} >> shift;
    nonzero = '0;
    for (int k = 0; k < PAT_BYTES; k++) begin
      nonzero[k] = |pattern[PAT_W-1-8*k -: 8];
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - XOR sprite draw and framebuffer clear engine with collision flag
// Optional feature macro: CHIP8_SPRITE16_EN (n = 0 draws a 16x16 sprite).
// Ports: clk, reset (sync, active high); draw/clear command pulses; wrap (1 = wrap, 0 = clip);
//        address (sprite base I), sprite_height (n), x/y (origin);
//        busy, done (1-cycle pulse), collision (VF);
//        mem_read_address/enable, mem_read_data (valid the cycle after the address);
//        mem_write_address/data/enable (driven 0 when not writing).
module sprite_blitter
  import ppu_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                SCREEN_W = 64,
  parameter int                SCREEN_H = 32,
  parameter logic [ADDR_W-1:0] FB_BASE  = ADDR_W'('hF00)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw,
  input  logic              clear,
  input  logic              wrap,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        sprite_height,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_read_enable,
  input  logic [7:0]        mem_read_data,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [7:0]        mem_write_data,
  output logic              mem_write_enable
);

  localparam int FB_ROW_BYTES = fb_row_bytes(SCREEN_W);
  localparam int FB_BYTES     = fb_bytes(SCREEN_W, SCREEN_H);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, clr_cnt_q;
  logic [15:0]       x0_q, y0_q;
  logic              wrap_q, collision_q;
  logic [4:0]        n_q, r_q;
  logic [1:0]        k_q;
  logic [SPR_W-1:0]  row_data_q;
  logic [7:0]        old_q;

  logic [SPR_W-1:0]     cur_sprite, spr_in;
  logic [PAT_W-1:0]     pattern;
  logic [PAT_BYTES-1:0] nonzero, valid;
  logic [7:0]           pat_byte;
  logic [15:0]          col_base, row_sum, row_y, col_raw, col;
  logic [1:0]           next_k;
  logic                 has_next, row_end_done, first_half;
  logic [ADDR_W-1:0]    spr_addr, fb_addr;

`ifdef CHIP8_SPRITE16_EN
  logic wide_q, half_q;
  localparam state_t ZERO_N_STATE = SPR_RD;
  assign first_half = wide_q && !half_q;
  assign cur_sprite = wide_q ? {row_data_q[15:8], mem_read_data} : {mem_read_data, 8'h00};
  assign spr_addr   = wide_q ? addr_q + ADDR_W'({r_q, half_q}) : addr_q + ADDR_W'(r_q);
`else
  localparam state_t ZERO_N_STATE = DONE;
  assign first_half = 1'b0;
  assign cur_sprite = mem_read_data;
  assign spr_addr   = addr_q + ADDR_W'(r_q);
`endif

  // In SPR_LATCH the row is taken straight off the read port so the skip
  // decision costs no extra cycle; afterwards the latched copy is used.
  assign spr_in = (state_q == SPR_LATCH) ? cur_sprite : row_data_q;

  sprite_row_shifter u_shifter (
    .sprite  (spr_in),
    .shift   (x0_q[2:0]),
    .pattern (pattern),
    .nonzero (nonzero)
  );

  always_comb begin
    col_base = x0_q >> 3;
    row_sum  = y0_q + 16'(r_q);
    row_y    = row_sum & 16'(SCREEN_H - 1);
    col_raw  = col_base + 16'(k_q);
    col      = col_raw & 16'(FB_ROW_BYTES - 1);
    fb_addr  = FB_BASE + ADDR_W'(32'(row_y) * 32'(FB_ROW_BYTES) + 32'(col));
    pat_byte = '0;
    valid    = '0;
    for (int k = 0; k < PAT_BYTES; k++) begin
      if (2'(k) == k_q) pat_byte = pattern[PAT_W-1-8*k -: 8];
      valid[k] = nonzero[k] && (wrap_q || (col_base + 16'(k) < 16'(FB_ROW_BYTES)));
    end
    // Lowest-numbered pending byte after the current one (any byte when a row starts).
    has_next = 1'b0;
    next_k   = '0;
    for (int k = PAT_BYTES - 1; k >= 0; k--) begin
      if (valid[k] && ((state_q == SPR_LATCH) || (2'(k) > k_q))) begin
        has_next = 1'b1;
        next_k   = 2'(k);
      end
    end
    row_end_done = (r_q + 5'd1 == n_q) ||
                   (!wrap_q && (row_sum + 16'd1 >= 16'(SCREEN_H)));
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (clear) state_d = CLR;
                 else if (draw) state_d = (sprite_height == 4'd0) ? ZERO_N_STATE : SPR_RD;
      CLR:       if (clr_cnt_q == ADDR_W'(FB_BYTES - 1)) state_d = DONE;
      SPR_RD:    state_d = SPR_LATCH;
      SPR_LATCH: if (first_half)        state_d = SPR_RD;
                 else if (has_next)     state_d = FB_RD;
                 else if (row_end_done) state_d = DONE;
                 else                   state_d = SPR_RD;
      FB_RD:     state_d = FB_WAIT;
      FB_WAIT:   state_d = FB_WR;
      FB_WR:     if (has_next)          state_d = FB_RD;
                 else if (row_end_done) state_d = DONE;
                 else                   state_d = SPR_RD;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != IDLE) && (state_q != DONE);
    done              = (state_q == DONE);
    collision         = collision_q;
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    case (state_q)
      SPR_RD: begin mem_read_enable = 1'b1; mem_read_address = spr_addr; end
      FB_RD:  begin mem_read_enable = 1'b1; mem_read_address = fb_addr;  end
      CLR:    begin mem_write_enable = 1'b1; mem_write_address = FB_BASE + clr_cnt_q; end
      FB_WR:  begin
        mem_write_enable  = 1'b1;
        mem_write_address = fb_addr;
        mem_write_data    = old_q ^ pat_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      clr_cnt_q   <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      wrap_q      <= 1'b0;
      collision_q <= 1'b0;
      n_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      row_data_q  <= '0;
      old_q       <= '0;
`ifdef CHIP8_SPRITE16_EN
      wide_q      <= 1'b0;
      half_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            clr_cnt_q   <= '0;
            collision_q <= 1'b0;
          end else if (draw) begin
            addr_q      <= address;
            x0_q        <= 16'(x) & 16'(SCREEN_W - 1);
            y0_q        <= 16'(y) & 16'(SCREEN_H - 1);
            wrap_q      <= wrap;
            r_q         <= '0;
            k_q         <= '0;
            collision_q <= 1'b0;
`ifdef CHIP8_SPRITE16_EN
            wide_q      <= (sprite_height == 4'd0);
            half_q      <= 1'b0;
            n_q         <= (sprite_height == 4'd0) ? 5'd16 : {1'b0, sprite_height};
`else
            n_q         <= {1'b0, sprite_height};
`endif
          end
        end
        CLR: clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        SPR_LATCH: begin
          if (first_half) begin
            row_data_q <= SPR_W'({mem_read_data, 8'h00});
`ifdef CHIP8_SPRITE16_EN
            half_q     <= 1'b1;
`endif
          end else begin
            row_data_q <= cur_sprite;
            k_q        <= next_k;
            if (!has_next) begin
              r_q <= r_q + 5'd1;
`ifdef CHIP8_SPRITE16_EN
              half_q <= 1'b0;
`endif
            end
          end
        end
        FB_WAIT: old_q <= mem_read_data;
        FB_WR: begin
          collision_q <= collision_q | (|(old_q & pat_byte));
          k_q         <= next_k;
          if (!has_next) begin
            r_q <= r_q + 5'd1;
`ifdef CHIP8_SPRITE16_EN
            half_q <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter (default 64x32 build)
module tb_sprite_blitter;

  localparam int         W  = 64;
  localparam int         H  = 32;
  localparam logic [11:0] FB = 12'hF00;

  logic        clk = 1'b0;
  logic        reset, draw, clear, wrap;
  logic [11:0] address;
  logic [3:0]  sprite_height;
  logic [7:0]  x, y;
  logic        busy, done, collision;
  logic [11:0] mem_read_address, mem_write_address;
  logic        mem_read_enable, mem_write_enable;
  logic [7:0]  mem_read_data, mem_write_data;

  logic [7:0]  mem [0:4095];
  logic [7:0]  img [0:4095];
  logic        tb_we;
  logic [11:0] tb_wa;
  logic [7:0]  tb_wd;

  logic [11:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_lat, exp_coll;
  bit          sb_off = 1'b0;
  int          stray_writes = 0;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk               (clk),
    .reset             (reset),
    .draw              (draw),
    .clear             (clear),
    .wrap              (wrap),
    .address           (address),
    .sprite_height     (sprite_height),
    .x                 (x),
    .y                 (y),
    .busy              (busy),
    .done              (done),
    .collision         (collision),
    .mem_read_address  (mem_read_address),
    .mem_read_enable   (mem_read_enable),
    .mem_read_data     (mem_read_data),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable)
  );

  always @(posedge clk) begin
    if (mem_read_enable)  mem_read_data <= mem[mem_read_address];
    if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
    if (tb_we)            mem[tb_wa] <= tb_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_wr_overlap", 32'(mem_read_enable & mem_write_enable), 0);
    if (!mem_write_enable) begin
      chk("idle_write_bus", {12'b0, mem_write_address, mem_write_data}, 0);
    end else if (sb_off) begin
      stray_writes++;
    end else begin
      n_assert++;
      assert (exp_a.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed write %0h at %0h expected none",
               mem_write_data, mem_write_address);
      end
      if (exp_a.size() != 0) begin
        chk("write_addr", 32'(mem_write_address), 32'(exp_a.pop_front()));
        chk("write_data", 32'(mem_write_data), 32'(exp_d.pop_front()));
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1; img[a] = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < W * H / 8; i++) begin
      exp_a.push_back(FB + 12'(i));
      exp_d.push_back(8'h00);
      img[FB + 12'(i)] = 8'h00;
    end
    exp_lat = W * H / 8 + 1;
    exp_coll = 0;
  endtask

  task automatic model_draw(input logic [11:0] a, input logic [7:0] xx, input logic [7:0] yy,
                            input int nn, input bit wr);
    int x0, y0, yr, c;
    logic [15:0] pat;
    logic [7:0]  b, pb, old;
    logic [11:0] fa;
    x0 = int'(xx) % W;
    y0 = int'(yy) % H;
    exp_lat = 1;
    exp_coll = 0;
    for (int r = 0; r < nn; r++) begin
      yr = y0 + r;
      if (yr >= H) begin
        if (!wr) break;
        yr -= H;
      end
      exp_lat += 2;
      b = img[12'(int'(a) + r)];
      pat = 16'(b) << (8 - x0 % 8);
      for (int k = 0; k < 2; k++) begin
        pb = (k == 0) ? pat[15:8] : pat[7:0];
        if (pb == 8'h00) continue;
        c = x0 / 8 + k;
        if (c >= W / 8) begin
          if (!wr) continue;
          c -= W / 8;
        end
        fa = FB + 12'(yr * (W / 8) + c);
        old = img[fa];
        exp_a.push_back(fa);
        exp_d.push_back(old ^ pb);
        if ((old & pb) != 8'h00) exp_coll = 1;
        img[fa] = old ^ pb;
        exp_lat += 3;
      end
    end
  endtask

  task automatic issue(input bit d, input bit c, input logic [11:0] a, input logic [7:0] xx,
                       input logic [7:0] yy, input logic [3:0] n, input bit wr);
    draw = d; clear = c; address = a; x = xx; y = yy; sprite_height = n; wrap = wr;
    @(posedge clk); #1;
    draw = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int skip);
    int lat;
    logic busy_first;
    lat = skip;
    busy_first = 1'b0;
    do begin
      lat++;
      @(negedge clk);
      if (lat == skip + 1) busy_first = busy;
    end while (done !== 1'b1 && lat < 3000);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " collision"}, 32'(collision), 32'(exp_coll));
    chk({tag, " busy_at_done"}, 32'(busy), 0);
    chk({tag, " busy_after_accept"}, 32'(busy_first), 32'(exp_lat > skip + 1));
    chk({tag, " queue_drained"}, exp_a.size(), 0);
    @(posedge clk); #1;
    chk({tag, " done_single_pulse"}, 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1; draw = 1'b0; clear = 1'b0; wrap = 1'b0;
    address = '0; sprite_height = '0; x = '0; y = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < W * H / 8; i++) poke(FB + 12'(i), 8'hFF);
    for (int r = 0; r < 15; r++) poke(12'h22A + 12'(r), 8'(17 * (r + 1)) ^ 8'h5A);
    poke(12'h300, 8'hFF);
    poke(12'h301, 8'hFF);
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset collision", 32'(collision), 0);
    chk("reset read_bus", {19'b0, mem_read_enable, mem_read_address}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    model_clear();
    issue(1'b0, 1'b1, 12'h0, 8'h0, 8'h0, 4'd0, 1'b0);
    wait_done("clear", 0);

    model_draw(12'h22A, 8'd8, 8'd0, 15, 1'b0);
    issue(1'b1, 1'b0, 12'h22A, 8'd8, 8'd0, 4'd15, 1'b0);
    wait_done("aligned", 0);
    chk("aligned row0 byte", 32'(mem[12'hF01]), 32'(8'(17) ^ 8'h5A));
    chk("aligned row14 byte", 32'(mem[12'hF71]), 32'(8'hFF ^ 8'h5A));

    // Redraw; a clear+draw pulse while busy must be ignored.
    model_draw(12'h22A, 8'd8, 8'd0, 15, 1'b0);
    issue(1'b1, 1'b0, 12'h22A, 8'd8, 8'd0, 4'd15, 1'b0);
    draw = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0; clear = 1'b0;
    wait_done("redraw", 1);
    chk("redraw row0 cleared", 32'(mem[12'hF01]), 0);

    model_draw(12'h300, 8'h3C, 8'h1F, 2, 1'b1);
    issue(1'b1, 1'b0, 12'h300, 8'h3C, 8'h1F, 4'd2, 1'b1);
    wait_done("wrap", 0);
    chk("wrap byte FFF", 32'(mem[12'hFFF]), 32'h0F);
    chk("wrap byte FF8", 32'(mem[12'hFF8]), 32'hF0);
    chk("wrap byte F07", 32'(mem[12'hF07]), 32'h0F);
    chk("wrap byte F00", 32'(mem[12'hF00]), 32'hF0);

    model_clear();
    issue(1'b0, 1'b1, 12'h0, 8'h0, 8'h0, 4'd0, 1'b0);
    wait_done("clear2", 0);

    model_draw(12'h300, 8'h3C, 8'h1F, 2, 1'b0);
    issue(1'b1, 1'b0, 12'h300, 8'h3C, 8'h1F, 4'd2, 1'b0);
    wait_done("clip", 0);
    chk("clip byte FFF", 32'(mem[12'hFFF]), 32'h0F);
    chk("clip byte FF8", 32'(mem[12'hFF8]), 0);

    model_draw(12'h22A, 8'h85, 8'd40, 3, 1'b0);
    issue(1'b1, 1'b0, 12'h22A, 8'h85, 8'd40, 4'd3, 1'b0);
    wait_done("unaligned", 0);

    model_draw(12'h22A, 8'd3, 8'd3, 0, 1'b1);
    issue(1'b1, 1'b0, 12'h22A, 8'd3, 8'd3, 4'd0, 1'b1);
    wait_done("n_zero", 0);

    // Reset in cycle 10 of a 15-row draw.
    sb_off = 1'b1;
    issue(1'b1, 1'b0, 12'h22A, 8'd8, 8'd0, 4'd15, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stray_writes = 0;
    @(negedge clk);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset done", 32'(done), 0);
    repeat (40) @(negedge clk);
    chk("midreset no_writes", stray_writes, 0);
    @(posedge clk); #1;
    sb_off = 1'b0;

    model_clear();
    issue(1'b1, 1'b1, 12'h22A, 8'd8, 8'd0, 4'd15, 1'b0);
    wait_done("draw_and_clear", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised CHIP-8 sprite engine, successor to the fixed 64x32 PPU. It XOR-draws n-row sprites from RAM into a RAM-resident framebuffer and reports pixel collision. Display geometry is set by parameter, and edge behaviour (clip or wrap) is selected per command. It also adds a hardware clear-screen command. It sits between the CPU core, which issues DXYN/00E0, and the shared chip8_ram: one registered read port, one write port.

## Interface
- ADDR_W, 12: memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- SCREEN_W, 64: display width in pixels; power of two, ≥ 16.
- SCREEN_H, 32: display height in pixels; power of two.
- FB_BASE, 12'hF00: framebuffer base address; row-major, SCREEN_W/8 bytes per row, bit 7 = leftmost pixel.
- clk  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- draw  in  1  start sprite draw; single-cycle pulse.
- clear  in  1  start framebuffer clear; single-cycle pulse.
- wrap  in  1  1 = off-screen pixels wrap around the edges; 0 = off-screen pixels are clipped.
- address  in  ADDR_W  sprite base (I).
- sprite_height  in  4  n, rows to draw.
- x, y  in  8  sprite origin (Vx, Vy).
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- collision  out  1  VF result of the last draw.
- mem_read_address  out  ADDR_W; mem_read_enable  out  1; mem_read_data  in  8. Data is valid in the cycle after the address is issued.
- mem_write_address  out  ADDR_W; mem_write_data  out  8; mem_write_enable  out  1.

## Operation
- Reset: all outputs 0, state IDLE.
- Command acceptance:
  - draw/clear are sampled only in IDLE and ignored while busy.
  - If both are asserted in the same cycle, clear wins.
  - All command inputs are latched at acceptance.
- Start position: x0 = x mod SCREEN_W, y0 = y mod SCREEN_H. The start position always wraps.
- States: IDLE, CLR, SPR_RD, SPR_LATCH, FB_RD, FB_WAIT, FB_WR, DONE.
- CLR:
  - Writes 0x00 to FB_BASE … FB_BASE+SCREEN_W*SCREEN_H/8−1, one byte per cycle, in ascending order.
  - collision is cleared.
- Draw, for each row r in 0..n−1:
  - SPR_RD issues address+r.
  - SPR_LATCH captures the byte and forms a 16-bit pattern = byte << (8 − x0%8).
  - Each pattern byte that is nonzero and on-screen gets FB_RD → FB_WAIT → FB_WR:
    - new = old ^ pat;
    - collision |= |(old & pat).
  - Zero pattern bytes are skipped at no cycle cost.
- Right edge:
  - Column byte c = x0/8 + k.
  - If c ≥ SCREEN_W/8: with wrap=0 the byte is skipped; with wrap=1, c −= SCREEN_W/8 (same row).
- Bottom edge:
  - Row yr = y0 + r.
  - If yr ≥ SCREEN_H: with wrap=0 the draw ends (DONE); with wrap=1, yr −= SCREEN_H.
- n = 0 draws nothing: IDLE → DONE, no memory access (see Configuration).
- collision is reset to 0 at draw acceptance and holds its final value until the next draw or clear.
- Reset mid-command: IDLE on the next cycle, no further writes. Framebuffer bytes already written stay modified.

## Timing
- busy rises the cycle after acceptance and falls in the same cycle done pulses.
- Sprite fetch: 2 cycles per row. Framebuffer update: 3 cycles per written byte. DONE: 1 cycle.
- Aligned x (x0%8 = 0): draw latency = 5n + 1 cycles from acceptance to done.
- Unaligned x, fully on-screen, all sprite bytes nonzero: 8n + 1 cycles.
- Clear: SCREEN_W*SCREEN_H/8 + 1 cycles (257 for 64x32).
- Read and write enables are never asserted in the same cycle.
- mem_write_* are valid only while mem_write_enable = 1; otherwise they are driven 0.

## Configuration
- CHIP8_SPRITE16_EN defined:
  - n = 0 draws a 16x16 sprite: 32 bytes, 2 per row, big-endian at address+2r.
  - The pattern widens to 24 bits, up to 3 framebuffer bytes per row.
  - Per-row cost becomes 4 + 3·(bytes written).
- CHIP8_SPRITE16_EN undefined: n = 0 is a no-op draw, done pulses 1 cycle after acceptance, and the 16-bit datapath is absent.

## Structure
- Package ppu_pkg holds:
  - the state enum;
  - localparams FB_ROW_BYTES = SCREEN_W/8 and FB_BYTES = SCREEN_W*SCREEN_H/8, as functions of the parameters;
  - the pattern width constant (16, or 24 under CHIP8_SPRITE16_EN).
- One sub-module, sprite_row_shifter (combinational), takes the sprite byte(s) and x0%8 and produces the pattern bytes plus a per-byte nonzero mask.
- The FSM, address generation and collision logic live in sprite_blitter.

## Test plan
- Clear, 64x32: pre-fill the framebuffer with 0xFF, pulse clear → 256 consecutive writes of 0x00 from 0xF00, done at cycle 257, collision = 0.
- Aligned draw: x=8, y=0, n=15, I=0x22A, blank screen → bytes written at 0xF01 + 8r equal ROM[0x22A+r], collision = 0, done at cycle 76.
- Redraw collision: repeat the same draw → all rows return to 0x00, collision = 1.
- Unaligned wrap: x=0x3C, y=0x1F, n=2, wrap=1, sprite 0xFF → row 31 gets 0x0F at 0xFFF and 0xF0 at 0xFF8; row 0 gets 0x0F at 0xF07 and 0xF0 at 0xF00.
- Clip: same command with wrap=0 → only 0xFFF is written (0x0F); done follows.
- Reset at cycle 10 of a 15-row draw → busy = 0 next cycle, no writes afterwards. Draw and clear pulsed in the same cycle → clear is performed.
